io_pins_readback: RTL and testbench

//  Input-side companion to the GPIO output/OE logic: samples the four 16-bit daughterboard io banks,

---
 rtl/io_pins_readback_pkg.sv | 34 +++
 rtl/io_pins_readback_bank.sv | 90 +++++++++
 rtl/io_pins_readback.sv | 100 ++++++++++
 tb/tb_io_pins_readback.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pins_readback_pkg.sv
// Shared types, register map and address-decode helper for the io pin readback block.
// Latency: n/a (declarations only).
// Backpressure: none; the config bus is fire-and-forget.
package io_pins_readback_pkg;

    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 16;

    // Register map entries mirrored from the shared fpga_regs definitions (bank 0 of each group).
    localparam logic [6:0] FR_IO_EDGE_0  = 7'd80;
    localparam logic [6:0] FR_IO_CLR_0   = 7'd84;
    localparam logic [6:0] FR_IO_IRQEN_0 = 7'd88;

    typedef logic [BANK_W-1:0] bank_t;

    // Readback word layout: sticky events in the upper half, synchronized pins in the lower half.
    typedef struct packed {
        bank_t events;
        bank_t pins;
    } rb_word_t;

    // One-hot per-bank write strobe for a register group starting at base.
    function automatic logic [NUM_BANKS-1:0] decode_bank(input logic [6:0] addr,
                                                         input logic [6:0] base,
                                                         input logic       strobe);
        logic [NUM_BANKS-1:0] hit;
        hit = '0;
        for (int n = 0; n < NUM_BANKS; n++) begin
            hit[n] = strobe && (addr == base + 7'(n));
        end
        return hit;
    endfunction

endpackage

// File: rtl/io_pins_readback_bank.sv
// One 16-bit bank: input synchronizer, edge select, sticky event and irq-enable registers.
// Latency: pad change to event set is SYNC_STAGES+1 clocks.
// Backpressure: none; writes take effect on the strobe cycle.
module io_bank_capture
    import io_pins_readback_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  bank_t       pad,
    input  logic        edge_we,
    input  logic        clr_we,
    input  logic        mask_we,
    input  logic [31:0] wr_data,
    input  logic        prime_done,
    output bank_t       pins,
    output bank_t       events,
    output bank_t       irq_en
);

    logic [SYNC_STAGES-1:0][BANK_W-1:0] sync_q;
    bank_t prev_q;
    bank_t edge_rise;
    bank_t edge_fall;
    bank_t new_edges;

    assign pins = sync_q[SYNC_STAGES-1];

    // Synchronizer chain for asynchronous pads; stage 0 is the metastability catcher.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pad;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Previous synchronized sample for edge comparison.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= pins;
        end
    end

    // Qualified edges; held off until the synchronizer has filled with real pad values.
    always_comb begin
        new_edges = '0;
        if (prime_done) begin
            new_edges = (pins & ~prev_q & edge_rise) | (~pins & prev_q & edge_fall);
        end
    end

    // Edge-select configuration: rising mask in the upper half, falling mask in the lower.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            edge_rise <= '0;
            edge_fall <= '0;
        end else if (edge_we) begin
            edge_rise <= wr_data[31:16];
            edge_fall <= wr_data[15:0];
        end
    end

    // Sticky events with write-1-to-clear; a fresh edge wins over a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            events <= '0;
        end else if (clr_we) begin
            events <= (events & ~wr_data[15:0]) | new_edges;
        end else begin
            events <= events | new_edges;
        end
    end

    // Irq enables: upper half selects which bits to update, lower half gives their new value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_en <= '0;
        end else if (mask_we) begin
            irq_en <= (irq_en & ~wr_data[31:16]) | (wr_data[15:0] & wr_data[31:16]);
        end
    end

endmodule

// File: rtl/io_pins_readback.sv
// Four-bank pad readback: address decode, priming counter, readback mux and irq aggregation.
// Latency: readback 1 clock from rb_sel; irq 1 clock after event/enable change.
// Backpressure: none; config writes are accepted on every strobe.
module io_pins_readback
    import io_pins_readback_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [6:0] ADDR_EDGE_BASE = FR_IO_EDGE_0,
    parameter logic [6:0] ADDR_CLR_BASE  = FR_IO_CLR_0,
    parameter logic [6:0] ADDR_MASK_BASE = FR_IO_IRQEN_0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] io_0,
    input  logic [15:0] io_1,
    input  logic [15:0] io_2,
    input  logic [15:0] io_3,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic [1:0]  rb_sel,
    output logic [31:0] readback_data,
    output logic        irq
);

    localparam int               PW        = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0]    PRIME_LEN = PW'(SYNC_STAGES + 1);

    bank_t                 pads   [NUM_BANKS];
    bank_t                 pins   [NUM_BANKS];
    bank_t                 events [NUM_BANKS];
    bank_t                 irq_en [NUM_BANKS];
    logic [NUM_BANKS-1:0]  edge_we;
    logic [NUM_BANKS-1:0]  clr_we;
    logic [NUM_BANKS-1:0]  mask_we;
    logic [PW-1:0]         prime_cnt;
    logic                  prime_done;
    logic                  irq_next;
    rb_word_t              rb_next;

    assign pads[0] = io_0;
    assign pads[1] = io_1;
    assign pads[2] = io_2;
    assign pads[3] = io_3;

    assign edge_we = decode_bank(serial_addr, ADDR_EDGE_BASE, serial_strobe);
    assign clr_we  = decode_bank(serial_addr, ADDR_CLR_BASE,  serial_strobe);
    assign mask_we = decode_bank(serial_addr, ADDR_MASK_BASE, serial_strobe);

    assign prime_done = (prime_cnt == PRIME_LEN);

    // Priming counter: saturates once the synchronizer and prev stage hold post-reset samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prime_cnt <= '0;
        end else if (!prime_done) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        io_bank_capture #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cap (
            .clock      (clock),
            .reset      (reset),
            .pad        (pads[g]),
            .edge_we    (edge_we[g]),
            .clr_we     (clr_we[g]),
            .mask_we    (mask_we[g]),
            .wr_data    (serial_data),
            .prime_done (prime_done),
            .pins       (pins[g]),
            .events     (events[g]),
            .irq_en     (irq_en[g])
        );
    end

    // Combine enabled events from every bank and build the selected readback word.
    always_comb begin
        irq_next = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            irq_next = irq_next | (|(events[b] & irq_en[b]));
        end
        rb_next.events = events[rb_sel];
        rb_next.pins   = pins[rb_sel];
    end

    // Registered outputs so the readback bus and interrupt line are glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readback_data <= '0;
            irq           <= 1'b0;
        end else begin
            readback_data <= rb_next;
            irq           <= irq_next;
        end
    end

endmodule

// File: tb/tb_io_pins_readback.sv
// Bench for io_pins_readback: directed scenarios plus random traffic against a cycle reference model.
// Latency: checks sampled 1 ns after each rising clock edge.
// Backpressure: n/a.
module tb_io_pins_readback;

    localparam int S = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0][15:0] pad;
    logic [6:0]       serial_addr;
    logic [31:0]      serial_data;
    logic             serial_strobe;
    logic [1:0]       rb_sel;
    logic [31:0]      readback_data;
    logic             irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: pad sample history per bank (index 0 = newest), config and events.
    logic [15:0] m_hist [4][0:S];
    logic [15:0] m_ev   [4];
    logic [15:0] m_en   [4];
    logic [15:0] m_rise [4];
    logic [15:0] m_fall [4];
    logic [31:0] m_rb;
    logic        m_irq;
    int          m_edges;

    io_pins_readback #(.SYNC_STAGES(S)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_0          (pad[0]),
        .io_1          (pad[1]),
        .io_2          (pad[2]),
        .io_3          (pad[3]),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .rb_sel        (rb_sel),
        .readback_data (readback_data),
        .irq           (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k <= S; k++) m_hist[b][k] = '0;
            m_ev[b]   = '0;
            m_en[b]   = '0;
            m_rise[b] = '0;
            m_fall[b] = '0;
        end
        m_rb    = '0;
        m_irq   = 1'b0;
        m_edges = 0;
    endtask

    // Apply one clock edge to the model using the inputs present just before that edge.
    task automatic model_edge();
        logic [31:0] nxt_rb;
        logic        nxt_irq;
        logic [15:0] sync, prev, newe;
        if (reset) begin
            model_reset();
            return;
        end
        m_edges++;
        nxt_rb  = {m_ev[rb_sel], m_hist[rb_sel][S-1]};
        nxt_irq = 1'b0;
        for (int b = 0; b < 4; b++) nxt_irq = nxt_irq | (|(m_ev[b] & m_en[b]));
        for (int b = 0; b < 4; b++) begin
            sync = m_hist[b][S-1];
            prev = m_hist[b][S];
            newe = (sync & ~prev & m_rise[b]) | (~sync & prev & m_fall[b]);
            if (m_edges < S + 2) newe = '0;
            if (serial_strobe && serial_addr == 7'(84 + b)) m_ev[b] = m_ev[b] & ~serial_data[15:0];
            m_ev[b] = m_ev[b] | newe;
            if (serial_strobe && serial_addr == 7'(80 + b)) begin
                m_rise[b] = serial_data[31:16];
                m_fall[b] = serial_data[15:0];
            end
            if (serial_strobe && serial_addr == 7'(88 + b))
                m_en[b] = (m_en[b] & ~serial_data[31:16]) | (serial_data[15:0] & serial_data[31:16]);
            for (int k = S; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = pad[b];
        end
        m_rb  = nxt_rb;
        m_irq = nxt_irq;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("rb_model", readback_data, m_rb);
        check("irq_model", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cfg_write(input logic [6:0] addr, input logic [31:0] data);
        serial_addr   = addr;
        serial_data   = data;
        serial_strobe = 1'b1;
        cycle();
        serial_strobe = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        pad           = '0;
        pad[0]        = 16'h00FF;
        pad[2]        = 16'h8000;
        serial_addr   = '0;
        serial_data   = '0;
        serial_strobe = 1'b0;
        rb_sel        = 2'd0;
        model_reset();
        #1;
        check("reset_rb", readback_data, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        run(3);
        reset = 1'b0;

        // Static-high pins through reset produce no events.
        run(10);
        check("t1_rb", readback_data, 32'h0000_00FF);
        check("t1_irq", {31'd0, irq}, 32'h0);

        // Rising edge on io_0[0]: event at T+3, irq and readback at T+4.
        cfg_write(7'd80, 32'h0001_0000);
        cfg_write(7'd88, 32'h0001_0001);
        pad[0] = 16'h0000;
        run(4);
        pad[0] = 16'h0001;
        run(3);
        check("t2_irq_t3", {31'd0, irq}, 32'h0);
        cycle();
        check("t2_irq_t4", {31'd0, irq}, 32'h1);
        check("t2_rb", readback_data, 32'h0001_0001);

        // Falling-only on bank 2 bit 15.
        rb_sel = 2'd2;
        cfg_write(7'd82, 32'h0000_8000);
        pad[2] = 16'h0000;
        run(5);
        check("t3_fall", readback_data, 32'h8000_0000);
        cfg_write(7'd86, 32'h0000_8000);
        pad[2] = 16'h8000;
        run(5);
        check("t3_rise_ignored", readback_data, 32'h0000_8000);

        // Clear bank 0 bit 0, irq falls one cycle later.
        rb_sel = 2'd0;
        cfg_write(7'd84, 32'h0000_0001);
        check("t4_irq_hold", {31'd0, irq}, 32'h1);
        cycle();
        check("t4_irq_drop", {31'd0, irq}, 32'h0);
        // Edge and clear on the same cycle: the edge wins.
        pad[0] = 16'h0000;
        run(4);
        pad[0] = 16'h0001;
        run(2);
        cfg_write(7'd84, 32'h0000_0001);
        cycle();
        check("t4_set_beats_clr", {16'd0, readback_data[31:16]}, 32'h0001);
        check("t4_irq_set", {31'd0, irq}, 32'h1);
        cfg_write(7'd84, 32'h0000_0001);
        cycle();
        check("t4_irq_clr", {31'd0, irq}, 32'h0);

        // Bit-masked irq enable updates on bank 1.
        rb_sel = 2'd1;
        cfg_write(7'd81, 32'h00FF_0000);
        cfg_write(7'd89, 32'h00F0_00F0);
        cfg_write(7'd89, 32'h0030_0000);
        pad[1] = 16'h0010;
        run(5);
        check("t5_bit4_rb", readback_data, 32'h0010_0010);
        check("t5_bit4_irq", {31'd0, irq}, 32'h0);
        pad[1] = 16'h0090;
        run(5);
        check("t5_bit7_rb", readback_data, 32'h0090_0090);
        check("t5_bit7_irq", {31'd0, irq}, 32'h1);

        // Events in every bank, then an asynchronous reset mid-cycle.
        for (int b = 0; b < 4; b++) cfg_write(7'(80 + b), 32'hFFFF_0000);
        rb_sel = 2'd3;
        pad    = {4{16'hFFFF}};
        run(5);
        check("t6_bank3_ev", readback_data, 32'hFFFF_FFFF);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_rb", readback_data, 32'h0);
        check("t6_async_irq", {31'd0, irq}, 32'h0);
        pad[1] = 16'h0000;
        run(2);
        reset = 1'b0;
        // io_0 stays high across release; io_1 bit 0 rises just before the second edge.
        cfg_write(7'd81, 32'hFFFF_0000);
        pad[1] = 16'h0001;
        cfg_write(7'd80, 32'hFFFF_0000);
        rb_sel = 2'd1;
        run(8);
        check("t6_late_event", readback_data, 32'h0001_0001);
        rb_sel = 2'd0;
        run(2);
        check("t6_primed", readback_data, 32'h0000_FFFF);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0)
                    pad[b] = pad[b] ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            serial_strobe = ($urandom_range(0, 3) == 0);
            serial_addr   = 7'($urandom_range(78, 93));
            serial_data   = $urandom;
            rb_sel        = 2'($urandom_range(0, 3));
            reset         = ($urandom_range(0, 399) == 0);
            cycle();
        end
        reset         = 1'b0;
        serial_strobe = 1'b0;
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
